// File: rtl/vga_gen_scheduler.sv
// Frame-level owner of the shared cell memory: display scan-out vs. Game-of-Life engine.
// Optional generation counter enabled by defining GOL_SCHED_GENCOUNT_EN; sched_state: 0 IDLE, 1 START, 2 UPDATE, 3 SWAP.
module vga_gen_scheduler #(
  parameter int H_ACTIVE       = 640,
  parameter int H_TOTAL        = 800,
  parameter int V_ACTIVE       = 480,
  parameter int V_TOTAL        = 525,
  parameter int FRAMES_PER_GEN = 30
) (
  input  logic                       pixelClk,
  input  logic                       rst,
  input  logic [$clog2(H_TOTAL)-1:0] hCount,
  input  logic [$clog2(V_TOTAL)-1:0] vCount,
  input  logic                       run,
  input  logic                       step,
  input  logic                       updReq,
  input  logic                       updDone,
  output logic                       dispGrant,
  output logic                       updGrant,
  output logic                       updStart,
  output logic                       bufSel,
  output logic                       frameTick,
  output logic                       overrun,
  output logic [15:0]                genCount,
  output logic [1:0]                 sched_state
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int FW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
  localparam logic [FW-1:0] FC_LAST  = FW'(FRAMES_PER_GEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    UPDATE = 2'd2,
    SWAP   = 2'd3
  } state_t;

  state_t        state;
  logic [FW-1:0] frame_cnt;
  logic          step_pending;
  logic          active;
  logic          vblank_entry;
  logic          frame_end;
  logic          trigger;

  assign active       = (hCount < H_ACT_C) && (vCount < V_ACT_C);
  assign vblank_entry = (hCount == '0) && (vCount == V_ACT_C);
  assign frame_end    = (hCount == H_LAST_C) && (vCount == V_LAST_C);
  assign trigger      = vblank_entry && (run ? (frame_cnt == FC_LAST) : step_pending);
  assign sched_state  = state;

`ifdef GOL_SCHED_GENCOUNT_EN
  logic [15:0] gen_cnt;
  assign genCount = gen_cnt;
`else
  assign genCount = 16'd0;
`endif

  // Engine handshake: updReq is a request held by the engine; a memory cycle
  // happens only in a cycle where updGrant is 1, the display never waits.
  always_ff @(posedge pixelClk) begin
    if (rst) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      step_pending <= 1'b0;
      dispGrant    <= 1'b0;
      updGrant     <= 1'b0;
      updStart     <= 1'b0;
      bufSel       <= 1'b0;
      frameTick    <= 1'b0;
      overrun      <= 1'b0;
`ifdef GOL_SCHED_GENCOUNT_EN
      gen_cnt      <= 16'd0;
`endif
    end else begin
      dispGrant <= active;
      updGrant  <= (state == UPDATE) && updReq && !active;
      frameTick <= vblank_entry;
      updStart  <= 1'b0;

      if (!run) begin
        frame_cnt <= '0;
      end else if (vblank_entry) begin
        frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
      end

      if (trigger) begin
        step_pending <= 1'b0;
      end else if (step && !run && (state == IDLE)) begin
        step_pending <= 1'b1;
      end

      if (trigger && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (trigger) state <= START;
        end
        START: begin
          updStart <= 1'b1;
          state    <= UPDATE;
        end
        UPDATE: begin
          if (updDone) state <= SWAP;
        end
        SWAP: begin
          // Toggling on the last pixel keeps bufSel stable for the whole next frame.
          if (frame_end) begin
            bufSel <= ~bufSel;
`ifdef GOL_SCHED_GENCOUNT_EN
            gen_cnt <= gen_cnt + 16'd1;
`endif
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_gen_scheduler.sv
// Self-checking bench for vga_gen_scheduler on a reduced 24x16 raster (16x8 visible).
// A second instance with FRAMES_PER_GEN=1 covers the overrun path.
module tb_vga_gen_scheduler;

  localparam int FRAME = 24 * 16;
  localparam logic [4:0] H_ACT  = 5'd16;
  localparam logic [4:0] H_LAST = 5'd23;
  localparam logic [3:0] V_ACT  = 4'd8;
  localparam logic [3:0] V_LAST = 4'd15;
`ifdef GOL_SCHED_GENCOUNT_EN
  localparam bit GEN_EN = 1'b1;
`else
  localparam bit GEN_EN = 1'b0;
`endif

  logic        pixelClk = 1'b0;
  logic        rst;
  logic [4:0]  hCount;
  logic [3:0]  vCount;
  logic        run, step, updReq, updDone;
  logic        run1, step1, updDone1;
  logic        dispGrant, updGrant, updStart, bufSel, frameTick, overrun;
  logic [15:0] genCount;
  logic [1:0]  sched_state;
  logic        dispGrant1, updGrant1, updStart1, bufSel1, frameTick1, overrun1;
  logic [15:0] genCount1;
  logic [1:0]  sched_state1;

  int          vec = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [4:0]  ph;
  logic [3:0]  pv;
  logic        pdone;
  logic [31:0] exp_q[$];

  vga_gen_scheduler #(.H_ACTIVE(16), .H_TOTAL(24), .V_ACTIVE(8), .V_TOTAL(16), .FRAMES_PER_GEN(2)) dut (
    .pixelClk(pixelClk), .rst(rst), .hCount(hCount), .vCount(vCount), .run(run), .step(step),
    .updReq(updReq), .updDone(updDone), .dispGrant(dispGrant), .updGrant(updGrant),
    .updStart(updStart), .bufSel(bufSel), .frameTick(frameTick), .overrun(overrun),
    .genCount(genCount), .sched_state(sched_state)
  );

  vga_gen_scheduler #(.H_ACTIVE(16), .H_TOTAL(24), .V_ACTIVE(8), .V_TOTAL(16), .FRAMES_PER_GEN(1)) dut1 (
    .pixelClk(pixelClk), .rst(rst), .hCount(hCount), .vCount(vCount), .run(run1), .step(step1),
    .updReq(updReq), .updDone(updDone1), .dispGrant(dispGrant1), .updGrant(updGrant1),
    .updStart(updStart1), .bufSel(bufSel1), .frameTick(frameTick1), .overrun(overrun1),
    .genCount(genCount1), .sched_state(sched_state1)
  );

  // ---------------- clock / reset ----------------
  always #5 pixelClk = ~pixelClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_active(logic [4:0] h, logic [3:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction
  function automatic bit is_vb(logic [4:0] h, logic [3:0] v);
    return (h == 5'd0) && (v == V_ACT);
  endfunction
  function automatic bit is_fe(logic [4:0] h, logic [3:0] v);
    return (h == H_LAST) && (v == V_LAST);
  endfunction
  function automatic logic [15:0] exp_gc(int n);
    return GEN_EN ? 16'(n) : 16'd0;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: capture what the DUT sampled, then present the next raster position.
  task automatic tick();
    @(posedge pixelClk);
    ph    = hCount;
    pv    = vCount;
    pdone = updDone;
    #1;
    cyc++;
    step    = 1'b0;
    updDone = 1'b0;
    if (hCount == H_LAST) begin
      hCount = 5'd0;
      vCount = (vCount == V_LAST) ? 4'd0 : vCount + 4'd1;
    end else begin
      hCount = hCount + 5'd1;
    end
  endtask

  // Release reset so the first live edge samples raster position (0,0).
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < FRAME + 2 && !(hCount == 5'd0 && vCount == 4'd0); i++) tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vec++; if (dispGrant !== 1'b0) begin bad++; $display("FAIL reset_dispGrant: got %b expected 0", dispGrant); end
    vec++; if (updGrant !== 1'b0) begin bad++; $display("FAIL reset_updGrant: got %b expected 0", updGrant); end
    vec++; if (updStart !== 1'b0) begin bad++; $display("FAIL reset_updStart: got %b expected 0", updStart); end
    vec++; if (bufSel !== 1'b0) begin bad++; $display("FAIL reset_bufSel: got %b expected 0", bufSel); end
    vec++; if (frameTick !== 1'b0) begin bad++; $display("FAIL reset_frameTick: got %b expected 0", frameTick); end
    vec++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    vec++; if (genCount !== 16'd0) begin bad++; $display("FAIL reset_genCount: got %0d expected 0", genCount); end
    vec++; if (sched_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", sched_state); end
    vec++; if ({dispGrant1, updGrant1, updStart1, bufSel1, frameTick1, overrun1, genCount1, sched_state1} !== 24'd0)
      begin bad++; $display("FAIL reset_dut1: got %h expected 0", {dispGrant1, updGrant1, updStart1, bufSel1, frameTick1, overrun1, genCount1, sched_state1}); end
  endtask

  task automatic test_free_run();
    int vb, frames, cd, grants;
    bit win, pend;
    logic exp_sel;
    int exp_gen;
    logic [31:0] e;
    vb = 0; frames = 0; cd = -1; grants = 0; win = 0; pend = 0; exp_sel = 1'b0; exp_gen = 0;
    exp_q.delete();
    run = 1'b1; updReq = 1'b1;
    do_reset();
    for (int i = 0; i < 8 * FRAME && frames < 6; i++) begin
      tick();
      if (is_vb(ph, pv)) begin
        vb++;
        if (vb % 2 == 0) exp_q.push_back(32'(cyc + 1));
      end
      vec++; if (frameTick !== is_vb(ph, pv)) begin bad++; $display("FAIL frame_tick: cyc %0d got %b expected %b", cyc, frameTick, is_vb(ph, pv)); end
      vec++; if (dispGrant !== is_active(ph, pv)) begin bad++; $display("FAIL disp_grant: cyc %0d got %b expected %b", cyc, dispGrant, is_active(ph, pv)); end
      vec++; if (updGrant !== (win && !is_active(ph, pv))) begin bad++; $display("FAIL upd_grant: cyc %0d got %b expected %b", cyc, updGrant, win && !is_active(ph, pv)); end
      vec++; if ((dispGrant & updGrant) !== 1'b0) begin bad++; $display("FAIL grant_excl: cyc %0d both grants 1, expected exclusive", cyc); end
      if (updGrant === 1'b1) grants++;
      if (is_fe(ph, pv) && pend) begin exp_sel = ~exp_sel; exp_gen++; pend = 0; end
      if (pdone && win) begin win = 0; pend = 1; end
      vec++; if (bufSel !== exp_sel) begin bad++; $display("FAIL free_bufSel: cyc %0d got %b expected %b", cyc, bufSel, exp_sel); end
      vec++; if (genCount !== exp_gc(exp_gen)) begin bad++; $display("FAIL free_genCount: cyc %0d got %0d expected %0d", cyc, genCount, exp_gc(exp_gen)); end
      if (updStart === 1'b1) begin
        vec++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL free_updStart: unexpected pulse at cyc %0d", cyc); end
        else begin
          e = exp_q.pop_front();
          if (e !== 32'(cyc)) begin bad++; $display("FAIL free_updStart: got cyc %0d expected cyc %0d", cyc, e); end
        end
        win = 1; cd = 100;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin updDone = 1'b1; cd = -1; end
      end
      if (is_fe(ph, pv)) frames++;
    end
    vec++; if (frames !== 6) begin bad++; $display("FAIL free_timeout: got %0d frames expected 6", frames); end
    vec++; if (exp_q.size() != 0) begin bad++; $display("FAIL free_missing_start: got %0d pending expected 0", exp_q.size()); end
    vec++; if (grants == 0) begin bad++; $display("FAIL free_no_grant: got 0 grant cycles expected >0"); end
    vec++; if (bufSel !== 1'b1) begin bad++; $display("FAIL free_final_bufSel: got %b expected 1", bufSel); end
    vec++; if (genCount !== exp_gc(3)) begin bad++; $display("FAIL free_final_genCount: got %0d expected %0d", genCount, exp_gc(3)); end
    run = 1'b0;
  endtask

  task automatic test_step();
    int starts;
    bit found;
    run = 1'b0; updReq = 1'b1; starts = 0; found = 0;
    do_reset();
    for (int i = 0; i < FRAME && vCount != 4'd3; i++) tick();
    step = 1'b1;
    tick();
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if (updStart === 1'b1) starts++;
      if (is_vb(ph, pv)) found = 1;
    end
    vec++; if (found !== 1'b1 || starts !== 0) begin bad++; $display("FAIL step_early: got %0d starts before vblank expected 0", starts); end
    tick();
    vec++; if (updStart !== 1'b1) begin bad++; $display("FAIL step_start: got %b at vblank+2 expected 1", updStart); end
    tick();
    vec++; if (updStart !== 1'b0) begin bad++; $display("FAIL step_pulse_width: got %b expected 0", updStart); end
    step = 1'b1;
    tick();
    starts = 0;
    repeat (FRAME + 64) begin
      tick();
      if (updStart === 1'b1) starts++;
    end
    vec++; if (starts !== 0) begin bad++; $display("FAIL step_ignored: got %0d starts expected 0", starts); end
    vec++; if (overrun !== 1'b0) begin bad++; $display("FAIL step_overrun: got %b expected 0", overrun); end
    vec++; if (bufSel !== 1'b0) begin bad++; $display("FAIL step_early_swap: got %b expected 0", bufSel); end
    updDone = 1'b1;
    tick();
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if (is_fe(ph, pv)) found = 1;
    end
    vec++; if (bufSel !== 1'b1) begin bad++; $display("FAIL step_swap: got %b expected 1", bufSel); end
    starts = 0;
    repeat (2 * FRAME) begin
      tick();
      if (updStart === 1'b1) starts++;
    end
    vec++; if (starts !== 0) begin bad++; $display("FAIL step_no_repeat: got %0d starts expected 0", starts); end
    vec++; if (genCount !== exp_gc(1)) begin bad++; $display("FAIL step_genCount: got %0d expected %0d", genCount, exp_gc(1)); end
  endtask

  task automatic test_coincident();
    bit found;
    int cnt;
    run = 1'b0; found = 0; cnt = 0;
    do_reset();
    step = 1'b1;
    tick();
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if (updStart === 1'b1) found = 1;
    end
    vec++; if (found !== 1'b1) begin bad++; $display("FAIL coin_start: got no updStart expected one"); end
    for (int i = 0; i < FRAME && !(hCount == H_LAST && vCount == V_LAST); i++) tick();
    updDone = 1'b1;
    tick();
    vec++; if (bufSel !== 1'b0) begin bad++; $display("FAIL coin_immediate: got %b expected 0", bufSel); end
    repeat (FRAME - 1) begin
      tick();
      if (bufSel !== 1'b0) cnt++;
    end
    vec++; if (cnt !== 0) begin bad++; $display("FAIL coin_hold: got %0d early-toggle cycles expected 0", cnt); end
    tick();
    vec++; if (bufSel !== 1'b1) begin bad++; $display("FAIL coin_toggle: got %b expected 1", bufSel); end
  endtask

  task automatic test_rst_mid();
    bit found;
    int vb, starts;
    logic [31:0] e;
    run = 1'b1; updReq = 1'b1; found = 0; vb = 0; starts = 0;
    do_reset();
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      tick();
      if (updStart === 1'b1) found = 1;
    end
    vec++; if (found !== 1'b1) begin bad++; $display("FAIL rst_mid_start: got no updStart expected one"); end
    repeat (4) tick();
    vec++; if (updGrant !== 1'b1) begin bad++; $display("FAIL rst_mid_grant: got %b expected 1", updGrant); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++; if ({dispGrant, updGrant, updStart, bufSel, frameTick, overrun, genCount, sched_state} !== 24'd0)
      begin bad++; $display("FAIL rst_mid_outputs: got %h expected 0", {dispGrant, updGrant, updStart, bufSel, frameTick, overrun, genCount, sched_state}); end
    exp_q.delete();
    for (int i = 0; i < 4 * FRAME && starts == 0; i++) begin
      tick();
      if (is_vb(ph, pv)) begin
        vb++;
        if (vb == 2) exp_q.push_back(32'(cyc + 1));
      end
      if (updStart === 1'b1) begin
        starts++;
        vec++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rst_mid_resume: early updStart at cyc %0d", cyc); end
        else begin
          e = exp_q.pop_front();
          if (e !== 32'(cyc)) begin bad++; $display("FAIL rst_mid_resume: got cyc %0d expected cyc %0d", cyc, e); end
        end
      end
    end
    vec++; if (starts !== 1) begin bad++; $display("FAIL rst_mid_count: got %0d starts expected 1", starts); end
    run = 1'b0;
  endtask

  task automatic test_overrun();
    int vb, starts, frames;
    logic [31:0] e;
    run = 1'b0; run1 = 1'b1; vb = 0; starts = 0; frames = 0;
    exp_q.delete();
    do_reset();
    for (int i = 0; i < 3 * FRAME + 10 && frames < 3; i++) begin
      tick();
      if (is_vb(ph, pv)) begin
        vb++;
        if (vb == 1) exp_q.push_back(32'(cyc + 1));
      end
      if (updStart1 === 1'b1) begin
        starts++;
        vec++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL ovr_start: unexpected pulse at cyc %0d", cyc); end
        else begin
          e = exp_q.pop_front();
          if (e !== 32'(cyc)) begin bad++; $display("FAIL ovr_start: got cyc %0d expected cyc %0d", cyc, e); end
        end
      end
      vec++; if (overrun1 !== (vb >= 2)) begin bad++; $display("FAIL ovr_flag: cyc %0d got %b expected %b", cyc, overrun1, vb >= 2); end
      vec++; if (bufSel1 !== 1'b0) begin bad++; $display("FAIL ovr_bufSel: cyc %0d got %b expected 0", cyc, bufSel1); end
      if (is_fe(ph, pv)) frames++;
    end
    vec++; if (starts !== 1) begin bad++; $display("FAIL ovr_count: got %0d starts expected 1", starts); end
    vec++; if (overrun1 !== 1'b1) begin bad++; $display("FAIL ovr_final: got %b expected 1", overrun1); end
    vec++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovr_missing: got %0d pending expected 0", exp_q.size()); end
    run1 = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; hCount = 5'd0; vCount = 4'd0;
    run = 1'b0; step = 1'b0; updReq = 1'b0; updDone = 1'b0;
    run1 = 1'b0; step1 = 1'b0; updDone1 = 1'b0;
    test_reset();
    test_free_run();
    test_step();
    test_coincident();
    test_rst_mid();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/vga_gen_scheduler.md
# vga_gen_scheduler

Frame-level scheduler that shares the single-port cell memory between the VGA display reader and the Game-of-Life update engine. It uses the free-running horizontal and vertical counters to decide when the display owns memory and when the engine may use it. It paces generations at a fixed frame rate or by single step, and swaps front/back buffers only on a frame boundary. It sits between the VGA timing counters and the cell-memory mux.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, total pixels per line
- V_ACTIVE, 480, visible lines per frame
- V_TOTAL, 525, total lines per frame
- FRAMES_PER_GEN, 30, frames between automatic generations (≥1)

Ports:
- pixelClk  in  1  pixel clock; only clock
- rst  in  1  synchronous, active-high reset
- hCount  in  $clog2(H_TOTAL)  horizontal counter, 0..H_TOTAL-1
- vCount  in  $clog2(V_TOTAL)  vertical counter, 0..V_TOTAL-1
- run  in  1  level; enables automatic generation pacing
- step  in  1  one-cycle pulse; requests one generation while run=0
- updReq  in  1  engine requests a memory cycle
- updDone  in  1  one-cycle pulse; engine finished the generation
- dispGrant  out  1  display reader owns memory
- updGrant  out  1  engine owns memory this cycle
- updStart  out  1  one-cycle pulse; start a generation
- bufSel  out  1  front (display) buffer index; engine writes !bufSel
- frameTick  out  1  one-cycle pulse at vblank entry
- overrun  out  1  sticky; a trigger arrived while a generation was in flight
- genCount  out  16  completed generations (see Configuration)

## Operation
- Active region: hCount<H_ACTIVE && vCount<V_ACTIVE.
- Vblank entry: hCount==0 && vCount==V_ACTIVE.
- Frame end: hCount==H_TOTAL-1 && vCount==V_TOTAL-1.
- dispGrant = registered active region. The display has absolute priority.
- updGrant = registered (state==UPDATE && updReq && !active region). dispGrant and updGrant are never both 1.
- frameCnt, range 0..FRAMES_PER_GEN-1, advances at each vblank entry while run=1 and wraps to 0. It holds at 0 while run=0.
- Trigger:
  - run=1: vblank entry with frameCnt==FRAMES_PER_GEN-1.
  - run=0: vblank entry with stepPending=1.
- stepPending is set by step while run=0 and state==IDLE. It is cleared when the trigger fires. A step received in any other state is ignored.
- FSM:
  - IDLE: on trigger → START.
  - START: assert updStart for exactly one cycle → UPDATE.
  - UPDATE: grant the engine outside the active region; on updDone → SWAP. Engine access may span several blanking intervals.
  - SWAP: on frame end, toggle bufSel, increment genCount → IDLE.
- A trigger in START, UPDATE or SWAP is dropped and sets overrun. Only rst clears overrun.
- updDone outside UPDATE is ignored.
- run dropping mid-generation does not abort it; the swap still occurs.
- Simultaneous updDone and frame end while in UPDATE: go to SWAP; the toggle waits for the next frame end.

## Timing
- All outputs are registered, with 1 cycle latency from hCount/vCount/updReq.
- Reset values, synchronous: dispGrant=0, updGrant=0, updStart=0, bufSel=0, frameTick=0, overrun=0, genCount=0, state=IDLE, frameCnt=0, stepPending=0.
- frameTick rises the cycle after the vblank-entry counter values.
- updStart rises 2 cycles after the vblank-entry counter values when the trigger fires.
- bufSel toggles the cycle after frame-end counter values, so it is stable across the whole next frame's active region.
- rst mid-generation forces IDLE immediately. updGrant drops the next cycle. The engine must treat rst as an abort.

## Configuration
- GOL_SCHED_GENCOUNT_EN defined: genCount is a 16-bit counter that increments on each swap and wraps from 0xFFFF to 0.
- GOL_SCHED_GENCOUNT_EN undefined: genCount is tied to 0 and the counter logic is absent.
- All other behaviour is identical in both builds.

## Test plan
- Free-run, FRAMES_PER_GEN=2, run=1, engine asserts updDone 100 cycles after updStart → updStart once per 2 frames; bufSel toggles at each following frame end; genCount=3 after 6 frames.
- updReq held high across a generation spanning active video → updGrant=0 whenever dispGrant=1; updGrant=1 only in blanking cycles; never both 1.
- run=0, step pulse mid-frame → exactly one updStart at next vblank entry+2; a second step during UPDATE is ignored; genCount=1.
- Engine never asserts updDone, run=1, FRAMES_PER_GEN=1 → one updStart, then overrun=1 at the next vblank entry; bufSel stays 0.
- updDone coincident with frame-end counters → bufSel toggles one full frame later, not immediately.
- rst asserted in UPDATE → next cycle all outputs equal reset values; with run=1, updStart resumes after FRAMES_PER_GEN frames.
